// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
//
// Purpose:
//    Receive-side companion of the clock divider. An asynchronous slow clock
//    or square wave arrives on sig_in and is sampled in the fast clk domain.
//    The block measures the rise-to-rise period and the sampled high time of
//    that waveform in clk cycles, and hands each finished measurement to a
//    consumer over a valid/ready output. It is used both to self-check
//    divider outputs and to measure external slow clocks.
//
// Parameters:
//    WIDTH       width of the period/high-time counters and outputs
//    TIMEOUT     clk cycles without a rising edge before no_signal asserts;
//                must be representable in WIDTH bits
//
// Ports:
//    clk         in   1      system clock, all logic on its rising edge
//    rst_n       in   1      asynchronous, active-low reset
//    sig_in      in   1      asynchronous waveform being measured
//    period      out  WIDTH  clk cycles between the last two rising edges
//    high_time   out  WIDTH  clk cycles sig_in was sampled high in that period
//    meas_valid  out  1      period/high_time hold an unconsumed measurement
//    meas_ready  in   1      consumer takes the measurement on valid&&ready
//    overrun     out  1      sticky: a measurement was overwritten unread
//    no_signal   out  1      no rising edge for TIMEOUT cycles, or none yet
// ---------------------------------------------------------------------------
module clk_period_meter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 200_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun,
   output logic             no_signal
);

   // Timeout limit expressed at counter width so the compare is width-exact.
   localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

   // IDLE waits for a first (arming) edge; MEASURE counts a full period.
   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hacc;

   // Synchronizer stages and the edge-detect history flop.
   logic s1;
   logic s2;
   logic prev;

   logic rise;
   logic accept;
   logic new_result;
   logic overwrite;
   logic [WIDTH-1:0] s2_ext;

   // ------------------------------------------------------------------------
   // Input path: two flops bring sig_in into the clk domain (s1 may go
   // metastable, s2 is the clean sample), and prev holds the previous clean
   // sample so a rising edge can be detected. The input-to-rise latency is
   // therefore two to three clk cycles depending on where the edge lands.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= sig_in;
         s2   <= s1;
         prev <= s2;
      end
   end

   // ------------------------------------------------------------------------
   // Combinational event decode shared by the FSM and the output handshake.
   //  rise       : clean rising edge of the synchronized waveform
   //  accept     : the consumer takes the presented result at this edge
   //  new_result : a complete period ends this cycle (only while measuring;
   //               the edge that arms the meter from IDLE closes no period)
   //  overwrite  : a new result replaces one the consumer has not taken
   // ------------------------------------------------------------------------
   always_comb begin
      rise       = s2 & ~prev;
      accept     = meas_valid & meas_ready;
      new_result = (state == MEASURE) & rise;
      overwrite  = new_result & meas_valid & ~meas_ready;
      s2_ext     = {{(WIDTH-1){1'b0}}, s2};
   end

   // ------------------------------------------------------------------------
   // Measurement FSM with registered outputs.
   //
   // The rising edge itself is the first cycle of a period and is sampled
   // high, so both counters restart at 1 on every edge. While measuring,
   // cnt counts every cycle and hacc counts only the cycles sampled high,
   // which keeps hacc <= cnt. When the next edge arrives, cnt is the exact
   // rise-to-rise distance and hacc is the high time of that period.
   //
   // If cnt reaches TIMEOUT without an edge the input is declared dead:
   // the FSM drops back to IDLE with the counters frozen, and the next edge
   // merely re-arms measurement, because the gap it closes is not a valid
   // period. cnt can never pass TIMEOUT, so it cannot wrap.
   //
   // Handshake: a presented result stays stable until it is accepted. A
   // new result always wins the output registers; if it lands while the
   // old one is still unread and not being accepted, overrun latches. An
   // accept clears overrun only when no new result lands in the same cycle,
   // so a result loaded alongside an accept leaves overrun untouched.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         hacc       <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         overrun    <= 1'b0;
         no_signal  <= 1'b1;
      end else begin
         if (new_result) begin
            period     <= cnt;
            high_time  <= hacc;
            meas_valid <= 1'b1;
         end else if (accept) begin
            meas_valid <= 1'b0;
         end

         if (overwrite) begin
            overrun <= 1'b1;
         end else if (accept && !new_result) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rise) begin
                  state     <= MEASURE;
                  cnt       <= ONE_W;
                  hacc      <= ONE_W;
                  no_signal <= 1'b0;
               end
            end

            MEASURE: begin
               if (rise) begin
                  cnt  <= ONE_W;
                  hacc <= ONE_W;
               end else if (cnt == TIMEOUT_W) begin
                  state     <= IDLE;
                  no_signal <= 1'b1;
               end else begin
                  cnt  <= cnt + ONE_W;
                  hacc <= hacc + s2_ext;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
